rgb_proc_pipe: RTL and testbench
================================

# rgb_proc_pipe

Parametrised streaming pixel processor for the HDMI video path, the next generation of the fixed 8-bit `rgb_proc` stage. It sits between the video timing/source logic and the TMDS encoder. It applies one of eight colour operations, selected by `switch_i`, to a valid/ready pixel stream. The selected mode is latched only at frame start, which prevents tearing. Two of the modes use the previous pixel on the same line, so they need pixel history. Sync and data-enable sideband travel with their pixel through a 2-stage elastic pipeline.

## Interface
- `DataWidth`, default 8: bits per colour channel, range 4..12.
- `Threshold`, default `2**(DataWidth-1)`: comparison level for threshold mode.
- `clk_i`, input, 1: clock. One clock domain.
- `rst_ni`, input, 1: reset. Asynchronous, active-low.
- `switch_i`, input, 3: mode request. Sampled only at frame start.
- `r_i` / `g_i` / `b_i`, input, DataWidth each: input pixel.
- `hsync_i` / `vsync_i` / `vde_i`, input, 1 each: input sideband.
- `valid_i`, input, 1: input beat valid.
- `ready_o`, output, 1: block can accept a beat.
- `r_o` / `g_o` / `b_o`, output, DataWidth each: processed pixel.
- `hsync_o` / `vsync_o` / `vde_o`, output, 1 each: delayed sideband.
- `valid_o`, output, 1: output beat valid.
- `ready_i`, input, 1: downstream accepts the beat.

## Operation
- A beat is accepted when `valid_i && ready_o`. A beat is emitted when `valid_o && ready_i`.
- Mode register:
  - Resets to 0.
  - Loads `switch_i` on an accepted beat with `vsync_i=1` when the previous accepted beat had `vsync_i=0`. This is a rising edge of vsync over accepted beats. The vsync history register resets to 0.
  - The beat that loads the register is already processed with the new mode.
- History register:
  - Holds the previous channel values plus a `prev_vld` flag.
  - An accepted beat with `vde_i=1` stores its pixel and sets `prev_vld`.
  - An accepted beat with `vde_i=0` clears `prev_vld`.
  - Reset clears `prev_vld`.
- Modes, applied to each channel `c`, with `M = 2**DataWidth-1`:
  - 0 passthrough.
  - 1 invert: `M-c`.
  - 2 grayscale: all channels get `(r+2g+b)>>2`. The sum is computed at DataWidth+2 bits with no overflow.
  - 3 swap: r and b are exchanged.
  - 4 threshold: `c>=Threshold ? M : 0`.
  - 5 red only: g=b=0.
  - 6 horizontal average: `(c+prev_c)>>1`. The sum is DataWidth+1 bits and is truncated. When `prev_vld=0`, the output is `c`.
  - 7 horizontal edge: `|c-prev_c|`. When `prev_vld=0`, the output is 0.
- Beats with `vde_i=0` output r=g=b=0 in every mode. Their sideband is still propagated.
- `hsync`, `vsync` and `vde` are copied unchanged and stay aligned with their pixel.
- Every accepted beat is emitted exactly once and in order. The block never drops, duplicates or creates beats.

## Timing
- Pipeline:
  - Two register stages, S1 and S2. S2 drives the outputs directly from registers.
  - A stage loads when it is empty or its contents are leaving.
  - `ready_o = !s1_vld || !s2_vld || ready_i`. This is combinational from state and `ready_i`.
- Latency is exactly 2 cycles from acceptance to `valid_o`. Throughput is 1 beat per cycle while `ready_i=1`.
- Bubbles collapse: an empty S2 is filled even while `ready_i=0`. Up to 2 beats are buffered under backpressure.
- While `valid_o && !ready_i`, all outputs are held stable.
- Mode and history are evaluated at acceptance, so backpressure does not change results.
- Reset values: `valid_o=0`, `ready_o=1`, r/g/b=0, hsync/vsync/vde=0, mode=0.
- Asserting `rst_ni` mid-stream empties the pipeline immediately and asynchronously. Buffered beats are discarded.

## Test plan
1. Reset, then mode 0, accept (0x12,0x34,0x56) with vde=1 -> the same pixel appears 2 cycles later with `valid_o=1`. During reset all outputs are 0 and `ready_o=1`.
2. Set `switch_i=1` mid-frame -> output stays passthrough. Then send a vsync rising beat with (0x10,0x80,0xFF) -> output (0xEF,0x7F,0x00), and invert stays active on later beats.
3. Mode 2, pixel (0x40,0x80,0xC0) -> (0x80,0x80,0x80). Mode 4, pixel (0x7F,0x80,0xFF) -> (0x00,0xFF,0xFF).
4. Mode 6: send a blanking beat, then r=0x10, then r=0x30 -> output r = 0x00, 0x10, 0x20. The same sequence in mode 7 -> 0x00, 0x00, 0x20.
5. Continuous input of beats 1..10 with `ready_i=0` for cycles 3..7 -> `ready_o` drops once 2 beats are buffered, outputs hold stable, and all 10 beats are emitted in order.
6. Mode 3 active, assert `rst_ni=0` while 2 beats are buffered -> `valid_o` goes to 0 immediately, and after release mode is 0 (passthrough).

Source files
------------

// File: rtl/rgb_proc_pipe.sv
// Streaming RGB pixel processor: eight colour modes latched at frame start,
// with sideband carried through a 2-stage elastic valid/ready pipeline.
module rgb_proc_pipe #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Threshold = 2**(DataWidth-1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [2:0]           switch_i,
    input  logic [DataWidth-1:0] r_i,
    input  logic [DataWidth-1:0] g_i,
    input  logic [DataWidth-1:0] b_i,
    input  logic                 hsync_i,
    input  logic                 vsync_i,
    input  logic                 vde_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DataWidth-1:0] r_o,
    output logic [DataWidth-1:0] g_o,
    output logic [DataWidth-1:0] b_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 vde_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int unsigned   DW     = DataWidth;
    localparam logic [DW-1:0] MaxVal = {DW{1'b1}};
    localparam logic [DW-1:0] ThrVal = DW'(Threshold);

    typedef struct packed {
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        logic          hsync;
        logic          vsync;
        logic          vde;
    } pix_t;

    logic            w_acc;
    logic            w_s1_load;
    logic            w_s2_load;
    logic            w_mode_load;
    logic [2:0]      w_mode;
    logic [DW+1:0]   w_gray_sum;
    pix_t            w_pix;

    logic [2:0]      r_mode;
    logic            r_vs_prev;
    logic [DW-1:0]   r_prev_r;
    logic [DW-1:0]   r_prev_g;
    logic [DW-1:0]   r_prev_b;
    logic            r_prev_vld;
    pix_t            r_s1;
    pix_t            r_s2;
    logic            r_s1_vld;
    logic            r_s2_vld;

    function automatic logic [DW-1:0] f_thr(input logic [DW-1:0] c);
        return (c >= ThrVal) ? MaxVal : '0;
    endfunction

    function automatic logic [DW-1:0] f_avg(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                            input logic pv);
        logic [DW:0] s;
        s = {1'b0, c} + {1'b0, p};
        return pv ? s[DW:1] : c;
    endfunction

    function automatic logic [DW-1:0] f_edge(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                             input logic pv);
        if (!pv) return '0;
        return (c >= p) ? (c - p) : (p - c);
    endfunction

    // Handshake: S2 moves when empty or draining, S1 moves when empty or feeding S2
    assign w_s2_load   = !r_s2_vld || ready_i;
    assign w_s1_load   = !r_s1_vld || w_s2_load;
    assign ready_o     = w_s1_load;
    assign w_acc       = valid_i && w_s1_load;
    assign w_mode_load = w_acc && vsync_i && !r_vs_prev;
    assign w_mode      = w_mode_load ? switch_i : r_mode;

    // Pixel operation, evaluated on the incoming beat with the effective mode
    always_comb begin
        w_pix       = '0;
        w_pix.hsync = hsync_i;
        w_pix.vsync = vsync_i;
        w_pix.vde   = vde_i;
        w_gray_sum  = {2'b00, r_i} + {1'b0, g_i, 1'b0} + {2'b00, b_i};
        if (vde_i) begin
            case (w_mode)
                3'd0: begin w_pix.r = r_i;          w_pix.g = g_i;          w_pix.b = b_i;          end
                3'd1: begin w_pix.r = MaxVal - r_i; w_pix.g = MaxVal - g_i; w_pix.b = MaxVal - b_i; end
                3'd2: begin
                    w_pix.r = w_gray_sum[DW+1:2];
                    w_pix.g = w_gray_sum[DW+1:2];
                    w_pix.b = w_gray_sum[DW+1:2];
                end
                3'd3: begin w_pix.r = b_i;          w_pix.g = g_i;          w_pix.b = r_i;          end
                3'd4: begin w_pix.r = f_thr(r_i);   w_pix.g = f_thr(g_i);   w_pix.b = f_thr(b_i);   end
                3'd5: begin w_pix.r = r_i;          w_pix.g = '0;           w_pix.b = '0;           end
                3'd6: begin
                    w_pix.r = f_avg(r_i, r_prev_r, r_prev_vld);
                    w_pix.g = f_avg(g_i, r_prev_g, r_prev_vld);
                    w_pix.b = f_avg(b_i, r_prev_b, r_prev_vld);
                end
                3'd7: begin
                    w_pix.r = f_edge(r_i, r_prev_r, r_prev_vld);
                    w_pix.g = f_edge(g_i, r_prev_g, r_prev_vld);
                    w_pix.b = f_edge(b_i, r_prev_b, r_prev_vld);
                end
            endcase
        end
    end

    // Mode, vsync edge tracking and same-line pixel history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode     <= 3'd0;
            r_vs_prev  <= 1'b0;
            r_prev_r   <= '0;
            r_prev_g   <= '0;
            r_prev_b   <= '0;
            r_prev_vld <= 1'b0;
        end else if (w_acc) begin
            r_mode    <= w_mode;
            r_vs_prev <= vsync_i;
            if (vde_i) begin
                r_prev_r   <= r_i;
                r_prev_g   <= g_i;
                r_prev_b   <= b_i;
                r_prev_vld <= 1'b1;
            end else begin
                r_prev_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_vld <= valid_i;
                if (valid_i) r_s1 <= w_pix;
            end
            if (w_s2_load) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) r_s2 <= r_s1;
            end
        end
    end

    assign valid_o = r_s2_vld;
    assign r_o     = r_s2.r;
    assign g_o     = r_s2.g;
    assign b_o     = r_s2.b;
    assign hsync_o = r_s2.hsync;
    assign vsync_o = r_s2.vsync;
    assign vde_o   = r_s2.vde;

endmodule

// File: tb/tb_rgb_proc_pipe.sv
// Scoreboard bench for rgb_proc_pipe: directed beats push hand-computed
// expectations; a negedge monitor pops and compares every emitted beat.
module tb_rgb_proc_pipe;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } beat_t;

    logic       clk_i    = 1'b0;
    logic       rst_ni   = 1'b0;
    logic [2:0] switch_i = 3'd0;
    logic [7:0] r_i      = 8'd0;
    logic [7:0] g_i      = 8'd0;
    logic [7:0] b_i      = 8'd0;
    logic       hsync_i  = 1'b0;
    logic       vsync_i  = 1'b0;
    logic       vde_i    = 1'b0;
    logic       valid_i  = 1'b0;
    logic       ready_i  = 1'b1;
    logic       ready_o;
    logic [7:0] r_o, g_o, b_o;
    logic       hsync_o, vsync_o, vde_o, valid_o;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    logic  bp_phase  = 1'b0;
    logic  saw_stall = 1'b0;
    beat_t last_beat = '0;
    logic  last_hold = 1'b0;

    rgb_proc_pipe dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .switch_i(switch_i),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .vde_i(vde_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops on emission, stability check while stalled
    always @(negedge clk_i) begin
        beat_t cur;
        beat_t e;
        cur = beat_t'{r_o, g_o, b_o, hsync_o, vsync_o, vde_o};
        if (bp_phase && !ready_o) saw_stall = 1'b1;
        if (valid_o && last_hold) check("hold", 32'(cur), 32'(last_beat));
        last_hold = valid_o && !ready_i;
        last_beat = cur;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %0h expected none", cur);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 32'(cur), 32'(e));
            end
        end
    end

    // Drive one beat (hsync mirrors blanking) and queue its expected output
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic vs, input logic de, input logic [2:0] sw,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        logic acc;
        r_i = r; g_i = g; b_i = b;
        vsync_i = vs; vde_i = de; hsync_i = !de; switch_i = sw;
        valid_i = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk_i);
            acc = ready_o;
            if (acc) exp_q.push_back(beat_t'{er, eg, eb, !de, vs, de});
            @(posedge clk_i);
            #1;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        valid_i = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !valid_o) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state
        valid_i = 1'b1;
        @(negedge clk_i);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
        check("rst_side", {29'd0, hsync_o, vsync_o, vde_o}, 32'd0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: passthrough and 2-cycle latency
        send(8'h12, 8'h34, 8'h56, 1'b0, 1'b1, 3'd0, 8'h12, 8'h34, 8'h56);
        @(negedge clk_i);
        check("lat_cycle1", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        check("lat_cycle2", 32'(valid_o), 32'd1);
        @(posedge clk_i);
        #1;
        drain();

        // 2: mid-frame switch ignored, vsync rise loads invert
        send(8'h10, 8'h80, 8'hFF, 1'b0, 1'b1, 3'd1, 8'h10, 8'h80, 8'hFF);
        send(8'h10, 8'h80, 8'hFF, 1'b1, 1'b1, 3'd1, 8'hEF, 8'h7F, 8'h00);
        send(8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 3'd0, 8'hFE, 8'hFD, 8'hFC);
        send(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 8'hFF, 8'hFF, 8'hFF);

        // 3: grayscale, blanking, threshold
        send(8'h40, 8'h80, 8'hC0, 1'b1, 1'b1, 3'd2, 8'h80, 8'h80, 8'h80);
        send(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0, 3'd2, 8'h00, 8'h00, 8'h00);
        send(8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 3'd4, 8'h00, 8'hFF, 8'hFF);
        send(8'h80, 8'h7F, 8'h00, 1'b0, 1'b1, 3'd4, 8'hFF, 8'h00, 8'h00);

        // 4: horizontal average then horizontal edge
        send(8'h55, 8'h55, 8'h55, 1'b1, 1'b0, 3'd6, 8'h00, 8'h00, 8'h00);
        send(8'h10, 8'h20, 8'hFF, 1'b0, 1'b1, 3'd6, 8'h10, 8'h20, 8'hFF);
        send(8'h30, 8'h20, 8'h01, 1'b0, 1'b1, 3'd6, 8'h20, 8'h20, 8'h80);
        send(8'h55, 8'h55, 8'h55, 1'b1, 1'b0, 3'd7, 8'h00, 8'h00, 8'h00);
        send(8'h10, 8'h20, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 8'h00);
        send(8'h30, 8'h20, 8'h01, 1'b0, 1'b1, 3'd7, 8'h20, 8'h00, 8'hFE);
        drain();

        // 5: back-to-back beats with a backpressure window
        send(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
        drain();
        bp_phase = 1'b1;
        fork
            begin
                for (int i = 1; i <= 10; i++)
                    send(8'(i), 8'(i + 16), 8'(i + 32), 1'b0, 1'b1, 3'd5,
                         8'(i), 8'(i + 16), 8'(i + 32));
            end
            begin
                repeat (2) @(posedge clk_i);
                #1 ready_i = 1'b0;
                repeat (5) @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
        join
        drain();
        bp_phase = 1'b0;
        check("stall_seen", 32'(saw_stall), 32'd1);

        // 6: reset with two beats buffered under swap mode
        send(8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 3'd3, 8'h33, 8'h22, 8'h11);
        drain();
        ready_i = 1'b0;
        send(8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 3'd3, 8'h03, 8'h02, 8'h01);
        send(8'h04, 8'h05, 8'h06, 1'b0, 1'b1, 3'd3, 8'h06, 8'h05, 8'h04);
        @(negedge clk_i);
        check("full_valid_o", 32'(valid_o), 32'd1);
        check("full_ready_o", 32'(ready_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid_o", 32'(valid_o), 32'd0);
        check("arst_ready_o", 32'(ready_o), 32'd1);
        check("arst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        send(8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 3'd3, 8'h11, 8'h22, 8'h33);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
